// File: rtl/seq_sub_div_pkg.sv
// seq_sub_div shared types.
// FSM encoding and counter sizing helper.
package seq_sub_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SUB,
    DIV,
    FIX,
    DONE
  } state_t;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_sub_div_step.sv
// One restoring-division step.
// Shift in the next dividend bit, subtract if it fits.
module sub_div_step #(
  parameter int W = 8
) (
  input  logic [W:0] rem_i,
  input  logic [W:0] dvs_i,
  input  logic       bit_i,
  output logic [W:0] rem_o,
  output logic       q_o
);

  logic [W+1:0] sh;
  logic [W+1:0] trial;

  always_comb begin
    sh    = {rem_i, bit_i};
    trial = sh - {1'b0, dvs_i};
    q_o   = ~trial[W+1];
    rem_o = q_o ? trial[W:0] : sh[W:0];
  end

endmodule

// File: rtl/seq_sub_div.sv
// Multi-cycle signed (y - c) / b restoring divider.
// Valid/ready in, valid/ready out; remainder follows dividend sign.
module seq_sub_div
  import seq_sub_div_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] y,
  input  logic [width-1:0] c,
  input  logic [width-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] q,
  output logic [width-1:0] r,
  output logic             dz
);

  if (width < 2 || width > 36) begin : g_bad_width
    $error("seq_sub_div: width %0d outside 2..36", width);
  end

  localparam int CW = cnt_w(width);
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  state_t           state_q;
  logic [width-1:0] y_q, c_q, b_q;
  logic [width-1:0] dvd_q;
  logic [width:0]   dvs_q;
  logic [width:0]   rem_q;
  logic [width:0]   rem_d;
  logic             qbit_d;
  logic             sd_q, sb_q;
  logic [CW-1:0]    cnt_q;
  logic [width-1:0] q_q, r_q;
  logic             dz_q, ov_q;
  logic [width-1:0] d;

  function automatic logic [width-1:0] mag(input logic [width-1:0] x);
    return x[width-1] ? -x : x;
  endfunction

  assign d = y_q - c_q;

  sub_div_step #(.W(width)) u_step (
    .rem_i (rem_q),
    .dvs_i (dvs_q),
    .bit_i (dvd_q[width-1]),
    .rem_o (rem_d),
    .q_o   (qbit_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ov_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      y_q     <= '0;
      c_q     <= '0;
      b_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      sd_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            y_q     <= y;
            c_q     <= c;
            b_q     <= b;
            state_q <= SUB;
          end
        end
        SUB: begin
          sd_q    <= d[width-1];
          sb_q    <= b_q[width-1];
          dvd_q   <= mag(d);
          dvs_q   <= {1'b0, mag(b_q)};
          rem_q   <= '0;
          cnt_q   <= '0;
          state_q <= DIV;
        end
        DIV: begin
          rem_q <= rem_d;
          dvd_q <= {dvd_q[width-2:0], qbit_d};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= FIX;
        end
        FIX: begin
          // b == 0: quotient saturates to all ones, remainder is d itself
          if (b_q == '0) begin
            q_q  <= '1;
            r_q  <= d;
            dz_q <= 1'b1;
          end else begin
            q_q  <= (sd_q ^ sb_q) ? -dvd_q : dvd_q;
            r_q  <= sd_q ? -rem_q[width-1:0] : rem_q[width-1:0];
            dz_q <= 1'b0;
          end
          ov_q    <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            ov_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign q         = q_q;
  assign r         = r_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_seq_sub_div.sv
// Self-checking bench for seq_sub_div (width 8).
// Directed test-plan cases plus random ops against an arithmetic model.
module tb_seq_sub_div;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] y, c, b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] q, r;
  logic       dz;

  int errors = 0;
  int checks = 0;

  seq_sub_div #(.width(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .c         (c),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .dz        (dz)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [7:0] yy, cc, bb,
                                output logic [7:0] eq, er,
                                output logic edz);
    logic [7:0] d8;
    int di, bi;
    d8 = yy - cc;
    di = $signed(d8);
    bi = $signed(bb);
    if (bi == 0) begin
      eq = 8'hFF;
      er = d8;
      edz = 1'b1;
    end else begin
      eq = 8'(di / bi);
      er = 8'(di % bi);
      edz = 1'b0;
    end
  endfunction

  task automatic start_op(input logic [7:0] yy, cc, bb);
    int n;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("in_ready_before", 32'(in_ready), 32'd1);
    y = yy;
    c = cc;
    b = bb;
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    chk("accepted", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_check(input string tag, input logic [7:0] yy, cc, bb);
    int lat;
    logic [7:0] eq, er;
    logic edz;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clock);
      #1 lat++;
    end
    model(yy, cc, bb, eq, er, edz);
    chk({tag, "_lat"}, 32'(lat), 32'd10);
    chk({tag, "_q"}, 32'(q), 32'(eq));
    chk({tag, "_r"}, 32'(r), 32'(er));
    chk({tag, "_dz"}, 32'(dz), 32'(edz));
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    chk("idle_ov", 32'(out_valid), 32'd0);
    chk("idle_rdy", 32'(in_ready), 32'd1);
  endtask

  task automatic op(input string tag, input logic [7:0] yy, cc, bb);
    start_op(yy, cc, bb);
    wait_check(tag, yy, cc, bb);
    finish_op();
  endtask

  initial begin
    logic [7:0] hq, hr;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    y = '0;
    c = '0;
    b = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    reset = 1'b0;

    op("basic", 8'd50, 8'd8, 8'd6);
    op("signed", 8'hEC, 8'd3, 8'd4);
    op("wrap", 8'd100, 8'h9C, 8'd7);
    op("divzero", 8'd10, 8'd0, 8'd0);
    op("ovf", 8'h80, 8'd0, 8'hFF);
    op("negdiv", 8'd7, 8'd0, 8'hFE);

    // back-pressure with a competing request held on the input
    start_op(8'd30, 8'd2, 8'd5);
    wait_check("bp", 8'd30, 8'd2, 8'd5);
    hq = q;
    hr = r;
    y = 8'd77;
    c = 8'd0;
    b = 8'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      chk("bp_q", 32'(q), 32'(hq));
      chk("bp_r", 32'(r), 32'(hr));
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_ov", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    chk("bp_rel_rdy", 32'(in_ready), 32'd1);
    chk("bp_rel_ov", 32'(out_valid), 32'd0);
    @(posedge clock);
    #1 in_valid = 1'b0;
    chk("bp_acc2", 32'(in_ready), 32'd0);
    wait_check("bp2", 8'd77, 8'd0, 8'd3);
    finish_op();

    // abort during the 4th DIV iteration
    start_op(8'd100, 8'd0, 8'd3);
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    chk("abort_ov", 32'(out_valid), 32'd0);
    chk("abort_rdy", 32'(in_ready), 32'd1);
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_r", 32'(r), 32'd0);
    op("after_abort", 8'd9, 8'd0, 8'd2);

    for (int i = 0; i < 24; i++) begin
      logic [7:0] ry, rc, rb;
      ry = 8'($urandom);
      rc = 8'($urandom);
      rb = (i % 8 == 7) ? 8'd0 : 8'($urandom);
      op("rand", ry, rc, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
